// File: rtl/counter_display_array_if.sv
// rtl/counter_display_array_if.sv - control/status bundle for the counter display array
interface counter_display_array_if #(
    parameter int DIGITS = 3
) ();
    logic [DIGITS-1:0]   inc;
    logic                up_down;
    logic                carry_en;
    logic                sat_mode;
    logic                limit_set;
    logic                limit_clr;
    logic [4*DIGITS-1:0] count;
    logic                carry_out;
    logic [DIGITS-1:0]   seg_data;
    logic                shift_clk;
    logic                latch;
    logic                busy;

    modport master (
        output inc, up_down, carry_en, sat_mode, limit_set, limit_clr,
        input  count, carry_out, seg_data, shift_clk, latch, busy
    );

    modport slave (
        input  inc, up_down, carry_en, sat_mode, limit_set, limit_clr,
        output count, carry_out, seg_data, shift_clk, latch, busy
    );
endinterface

// File: rtl/counter_display_array.sv
// rtl/counter_display_array.sv - chained digit counters with serial 7-segment refresh
module counter_display_array #(
    parameter int DIGITS  = 3,
    parameter int RADIX   = 10,
    parameter int SEG_DIV = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    counter_display_array_if.slave   bus
);
    localparam logic [3:0] LIM_DEF = 4'(RADIX - 1);
    localparam int         DIV_W   = $clog2(SEG_DIV + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;

    logic [DIGITS-1:0][3:0] cnt_q, cnt_d, lim_q;
    logic [DIGITS-1:0][7:0] sh_q;
    logic [DIGITS-1:0]      seg;
    logic [4:0]             step_r;
    logic                   cin, cy_top, changed, carry_q;
    state_t                 state_q, state_d;
    logic                   start, pending_q, half_q, div_end;
    logic [DIV_W-1:0]       div_q;
    logic [2:0]             bit_q;

    // Returns {carry, next value} for one step of a single digit.
    function automatic logic [4:0] step_digit(input logic [3:0] v, input logic [3:0] lim,
                                              input logic dn, input logic sat);
        logic [4:0] r;
        r = {1'b0, v};
        if (!dn) begin
            if (v < lim)  r = {1'b0, v + 4'd1};
            else if (sat) r = {1'b0, lim};
            else          r = 5'b1_0000;
        end else begin
            if (v != 4'd0) r = {1'b0, v - 4'd1};
            else if (!sat) r = {1'b1, lim};
        end
        return r;
    endfunction

    function automatic logic [7:0] seg_font(input logic [3:0] d);
        case (d)
            4'h0: return 8'h3F;  4'h1: return 8'h06;  4'h2: return 8'h5B;  4'h3: return 8'h4F;
            4'h4: return 8'h66;  4'h5: return 8'h6D;  4'h6: return 8'h7D;  4'h7: return 8'h07;
            4'h8: return 8'h7F;  4'h9: return 8'h6F;  4'hA: return 8'h77;  4'hB: return 8'h7C;
            4'hC: return 8'h39;  4'hD: return 8'h5E;  4'hE: return 8'h79;  default: return 8'h71;
        endcase
    endfunction

    // Single pass from digit 0; the ring carry may step digit 0 but never re-propagates.
    always_comb begin
        cnt_d  = cnt_q;
        cin    = 1'b0;
        step_r = '0;
        for (int j = 0; j < DIGITS; j++) begin
            if (bus.inc[j] || (bus.carry_en && cin)) begin
                step_r   = step_digit(cnt_q[j], lim_q[j], bus.up_down, bus.sat_mode);
                cnt_d[j] = step_r[3:0];
                cin      = step_r[4];
            end else begin
                cin      = 1'b0;
            end
        end
        cy_top = cin;
        if (bus.carry_en && cy_top && !bus.inc[0]) begin
            step_r   = step_digit(cnt_q[0], lim_q[0], bus.up_down, bus.sat_mode);
            cnt_d[0] = step_r[3:0];
        end
    end

    assign changed = (cnt_d != cnt_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            lim_q   <= {DIGITS{LIM_DEF}};
            carry_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            carry_q <= cy_top;
            if (bus.limit_clr)      lim_q <= {DIGITS{LIM_DEF}};
            else if (bus.limit_set) lim_q <= cnt_q;
        end
    end

    assign div_end = (div_q == DIV_W'(SEG_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            IDLE:  if (pending_q) begin
                       state_d = LOAD;
                       start   = 1'b1;
                   end
            LOAD:  state_d = SHIFT;
            SHIFT: if (div_end && half_q && bit_q == 3'd7) state_d = LATCH;
            LATCH: if (div_end) begin
                       if (pending_q) begin
                           state_d = LOAD;
                           start   = 1'b1;
                       end else begin
                           state_d = IDLE;
                       end
                   end
            default: state_d = IDLE;
        endcase
    end

    // Clearing on start is safe: LOAD samples count one cycle later, after this edge's update.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= 1'b1;
            div_q     <= '0;
            half_q    <= 1'b0;
            bit_q     <= '0;
            sh_q      <= '0;
        end else begin
            pending_q <= (pending_q | changed) & ~start;
            case (state_q)
                LOAD: begin
                    for (int j = 0; j < DIGITS; j++) sh_q[j] <= seg_font(cnt_q[j]);
                    div_q  <= '0;
                    half_q <= 1'b0;
                    bit_q  <= '0;
                end
                SHIFT: begin
                    div_q <= div_end ? '0 : div_q + 1'b1;
                    if (div_end) begin
                        half_q <= ~half_q;
                        if (half_q) begin
                            bit_q <= bit_q + 3'd1;
                            for (int j = 0; j < DIGITS; j++) sh_q[j] <= {sh_q[j][6:0], 1'b0};
                        end
                    end
                end
                LATCH:   div_q <= div_end ? '0 : div_q + 1'b1;
                default: div_q <= '0;
            endcase
        end
    end

    always_comb begin
        seg = '0;
        if (state_q == SHIFT)
            for (int j = 0; j < DIGITS; j++) seg[j] = sh_q[j][7];
    end

    assign bus.count     = cnt_q;
    assign bus.carry_out = carry_q;
    assign bus.seg_data  = seg;
    assign bus.shift_clk = (state_q == SHIFT) && half_q;
    assign bus.latch     = (state_q == LATCH);
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: doc/counter_display_array.md
Name: counter_display_array

Overview:
Parametrised multi-digit counter with per-digit radix limits, selectable wrap/saturate, carry/borrow chaining and serial 7-segment refresh output.
Each digit has its own increment strobe and an upper limit that can be captured at runtime.
After every count change, the decoded segment patterns for all digits are shifted out in parallel, one serial line per digit, with a shared shift clock and latch.
The block sits downstream of the input synchronizer and drives the external shift-register displays.

Parameters:
DIGITS, 3, number of digits; each digit is 4 bits wide.
RADIX, 10, default digit limit is RADIX-1; legal range 2..16.
SEG_DIV, 4, shift_clk half-period in clk cycles; minimum 1.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
inc  in  DIGITS  per-digit single-cycle step strobe, already synchronized
up_down  in  1  direction: 0 = up, 1 = down
carry_en  in  1  1 = carry/borrow from digit j-1 steps digit j; the top digit feeds digit 0
sat_mode  in  1  0 = wrap at limits, 1 = saturate at limits
limit_set  in  1  pulse: capture current count as per-digit upper limits
limit_clr  in  1  pulse: restore every limit to RADIX-1
count  out  4*DIGITS  digit j occupies bits [4j+3:4j]
carry_out  out  1  1-cycle pulse on wrap/borrow of the top digit
seg_data  out  DIGITS  serial segment data, one line per digit
shift_clk  out  1  shared shift clock
latch  out  1  shared latch strobe
busy  out  1  high while a refresh frame is in progress

Behaviour:
- Reset: count=0, lim[j]=RADIX-1, carry_out=0, seg_data=0, shift_clk=0, latch=0, busy=0, refresh pending=1.
- Digit step request: step[j] = inc[j] OR (carry_en AND cy[j-1]). cy[-1] is cy[DIGITS-1] of the same cycle.
- The carry chain is combinational and evaluated on pre-update values. A ring-wrap loop is resolved by evaluating the chain once from digit 0; there is no re-propagation.
- A digit with both inc and carry-in asserted steps exactly once.
- Up, digit<lim: +1, cy=0.
- Up, digit==lim: sat_mode=0 gives 0 with cy=1; sat_mode=1 holds the value with cy=0.
- Down, digit>0: -1, cy=0.
- Down, digit==0: sat_mode=0 gives lim[j] with cy=1; sat_mode=1 holds 0 with cy=0.
- If digit>lim (possible after a lower capture): an up step goes to 0 with cy=1 (wrap) or loads lim (saturate); a down step decrements normally.
- count updates on the clk edge after the step (1-cycle latency).
- carry_out = registered cy of the top digit (1-cycle pulse).
- limit_set: lim[j] <= count[j] as it was before that cycle's step; the step in the same cycle uses the old limits.
- limit_clr has priority over limit_set. A captured limit of 0 pins the digit at 0; every step produces cy when wrapping.
- Refresh FSM states: IDLE, LOAD, SHIFT, LATCH.
- Any count change sets pending.
- IDLE with pending: go to LOAD and clear pending.
- LOAD (1 cycle): snapshot count, decode each digit to pattern {dp=0,g,f,e,d,c,b,a}. Hex font: 0=0x3F, 1=0x06, …, 9=0x6F, A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71.
- SHIFT: 8 bits, MSB first. Each bit is presented with shift_clk=0 for SEG_DIV cycles, then shift_clk=1 for SEG_DIV cycles. Data changes only while shift_clk is low.
- LATCH: shift_clk=0, seg_data=0, latch=1 for SEG_DIV cycles. Then go to LOAD if pending, else IDLE.
- Frame length = 1 + 16*SEG_DIV + SEG_DIV cycles. busy=1 from LOAD through the last LATCH cycle.
- Count changes during a frame do not disturb it: they set pending, and exactly one follow-up frame runs with the latest value.
- Reset mid-frame aborts immediately to reset values and pending=1; the first frame starts the cycle after reset deasserts.

Test Plan:
- Reset release, DIGITS=3, SEG_DIV=1 -> frame starts next cycle. seg_data[0..2] each shift 0x3F. latch high 1 cycle after 8 rising shift_clk edges. busy low after 18 cycles.
- count=9,9,9 (digit2..0), carry_en=1, up, pulse inc[0] -> count=0,0,0 next cycle; carry_out pulses 1 cycle; digit0 does not re-step from the ring carry.
- count=0,0,0, carry_en=0, down, sat_mode=0, inc=3'b111 -> 9,9,9. Repeat with sat_mode=1 -> stays 0,0,0, no carry_out.
- count=0,3,5, limit_set -> lim=(0,3,5). Repeated inc[0] up -> 0,1,2,3,4,5,0… Then limit_clr -> digit0 counts to 9.
- Two inc pulses 3 cycles apart during a busy frame -> one follow-up frame only, with the final value. No glitch on shift_clk or seg_data in the running frame.
- RADIX=16, count digit0=0xA -> pattern 0x77 shifted MSB first: bits 0,1,1,1,0,1,1,1.
